// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks one active-low column, debounces press/release on scan ticks, emits one code per press.
// Latency: key_valid rises 1 clk after the DEBOUNCE-th tick seen on the pressed key's column.
// Backpressure: single-entry output; a press arriving while key_valid && !key_ready is dropped and sets sticky overrun.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8,
    localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBNC, S_PRESSED} state_t;

    state_t            state;
    logic [ROWS-1:0]   row_m;
    logic [ROWS-1:0]   row_s;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [COL_W-1:0]  col_idx;
    logic [COL_W-1:0]  col_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rel_cnt;
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] code;
    logic [ROW_W-1:0]  hit_row;
    logic              hit;
    logic              emit;

    // Rows are asynchronous to clk; idle (pulled-up) value is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m   <= '1;
            row_s   <= '1;
            div_cnt <= '0;
        end else begin
            row_m   <= row_i;
            row_s   <= row_m;
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);
    assign hit  = ~&row_s;

    always_comb begin
        hit_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s[r]) hit_row = ROW_W'(r);
        end
    end

    assign code    = CODE_W'(int'(hit_row) * COLS + int'(col_idx));
    assign col_nxt = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;

    always_comb begin
        emit = 1'b0;
        if (tick && hit) begin
            case (state)
                S_SCAN:  emit = (DEBOUNCE == 1);
                S_DEBNC: emit = (code == cand) && (cnt == DEB_LAST);
                default: emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SCAN;
            col_idx  <= '0;
            col_o    <= ~(COLS'(1));
            cand     <= '0;
            cnt      <= '0;
            rel_cnt  <= '0;
            key_held <= 1'b0;
        end else if (tick) begin
            case (state)
                S_SCAN: begin
                    if (hit) begin
                        cand <= code;
                        if (DEBOUNCE == 1) begin
                            state    <= S_PRESSED;
                            key_held <= 1'b1;
                            rel_cnt  <= '0;
                        end else begin
                            state <= S_DEBNC;
                            cnt   <= CNT_W'(1);
                        end
                    end else begin
                        col_idx <= col_nxt;
                        col_o   <= ~(COLS'(1) << col_nxt);
                    end
                end
                S_DEBNC: begin
                    if (hit && code == cand) begin
                        if (cnt == DEB_LAST) begin
                            state    <= S_PRESSED;
                            key_held <= 1'b1;
                            rel_cnt  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state   <= S_SCAN;
                        col_idx <= col_nxt;
                        col_o   <= ~(COLS'(1) << col_nxt);
                    end
                end
                S_PRESSED: begin
                    // Any row low on the frozen column counts as still held.
                    if (hit) begin
                        rel_cnt <= '0;
                    end else if (rel_cnt == DEB_LAST) begin
                        state    <= S_SCAN;
                        key_held <= 1'b0;
                        col_idx  <= col_nxt;
                        col_o    <= ~(COLS'(1) << col_nxt);
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= code;
                    key_valid <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves overrun set.
            if (emit && key_valid && !key_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Random keypad bench: a physical keypad model drives rows from col_o, and a tick-level reference
// of the scan/debounce/handshake rules predicts every output each cycle.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int CODE_W   = 4;
    localparam int NCYC     = 6000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ROWS-1:0]   row_i;
    logic [COLS-1:0]   col_o;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_held;
    logic              overrun;
    logic              overrun_clr;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: what the scanner sees (two-clock-old rows), clocks since reset, and the abstract press tracker.
    logic [ROWS-1:0] m_s1, m_s2;
    int m_n, m_col, m_mode, m_cand, m_streak, m_quiet;
    int e_code;
    bit e_valid, e_held, e_ovr;

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1;
        m_n = 0; m_col = 0; m_mode = 0; m_cand = 0; m_streak = 0; m_quiet = 0;
        e_code = 0; e_valid = 0; e_held = 0; e_ovr = 0;
    endtask

    task automatic model_step();
        logic [ROWS-1:0] seen;
        int low;
        bit tk, emit, drop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = row_i;
        tk = ((m_n % SCAN_DIV) == SCAN_DIV - 1);
        m_n++;
        emit = 0;
        if (tk) begin
            low = -1;
            for (int r = 0; r < ROWS; r++) if (!seen[r] && low < 0) low = r;
            case (m_mode)
                0: if (low >= 0) begin
                       m_cand = low * COLS + m_col;
                       if (DEBOUNCE == 1) begin m_mode = 2; m_quiet = 0; emit = 1; end
                       else begin m_mode = 1; m_streak = 1; end
                   end else m_col = (m_col + 1) % COLS;
                1: if (low >= 0 && low * COLS + m_col == m_cand) begin
                       m_streak++;
                       if (m_streak == DEBOUNCE) begin m_mode = 2; m_quiet = 0; emit = 1; end
                   end else begin
                       m_mode = 0; m_col = (m_col + 1) % COLS;
                   end
                default: if (low < 0) begin
                       m_quiet++;
                       if (m_quiet == DEBOUNCE) begin m_mode = 0; m_col = (m_col + 1) % COLS; end
                   end else m_quiet = 0;
            endcase
        end
        drop = emit && e_valid && !key_ready;
        if (emit) begin
            if (!e_valid || key_ready) begin e_code = m_cand; e_valid = 1; end
        end else if (e_valid && key_ready) e_valid = 0;
        if (drop) e_ovr = 1;
        else if (overrun_clr) e_ovr = 0;
        e_held = (m_mode == 2);
    endtask

    task automatic do_checks();
        logic [COLS-1:0] ecol;
        ecol = ~(COLS'(1) << m_col);
        chk_eq("col_o", 32'(col_o), 32'(ecol));
        chk_eq("key_code", 32'(key_code), 32'(e_code));
        chk_eq("key_valid", 32'(key_valid), 32'(e_valid));
        chk_eq("key_held", 32'(key_held), 32'(e_held));
        chk_eq("overrun", 32'(overrun), 32'(e_ovr));
    endtask

    initial begin
        int pk_a, pk_b, left, bounce, phase, next_rst, seg;
        bit active, in_rst;
        logic [ROWS-1:0] rv;
        rst_n = 1'b0; row_i = '1; key_ready = 1'b0; overrun_clr = 1'b0;
        pk_a = -1; pk_b = -1; left = 10; bounce = 0; phase = 0; next_rst = 400; in_rst = 0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            do_checks();
        end
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            do_checks();
            if (in_rst) begin rst_n = 1'b1; in_rst = 0; end
            if (left == 0) begin
                if (phase == 0) begin
                    phase = 1;
                    pk_a = int'($urandom_range(0, 15));
                    pk_b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
                    left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : int'($urandom_range(30, 120));
                    bounce = int'($urandom_range(0, 8));
                end else begin
                    phase = 0;
                    left = int'($urandom_range(4, 80));
                    bounce = int'($urandom_range(0, 6));
                end
            end
            left--;
            active = (phase == 1);
            if (bounce > 0) begin bounce--; active = ($urandom_range(0, 1) == 1); end
            rv = '1;
            if (active) begin
                if (pk_a >= 0 && col_o[pk_a % COLS] == 1'b0) rv[pk_a / COLS] = 1'b0;
                if (pk_b >= 0 && col_o[pk_b % COLS] == 1'b0) rv[pk_b / COLS] = 1'b0;
            end
            row_i = rv;
            seg = (cyc / 1500) % 3;
            case (seg)
                0: key_ready = 1'b1;
                1: key_ready = ($urandom_range(0, 7) == 0);
                default: key_ready = ($urandom_range(0, 63) == 0);
            endcase
            overrun_clr = ($urandom_range(0, 39) == 0);
            if (cyc >= next_rst && phase == 1 && left > 30 && bounce == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                do_checks();
                in_rst = 1;
                next_rst = cyc + 900;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner with debounce for the calculator front end. It drives one keypad column low at a time and samples the row lines through a 2-FF synchroniser. It debounces presses and releases, then delivers one key code per press over a valid/ready handshake to the calculator control FSM. Rows, columns, scan rate and debounce depth are all parameters.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 4, number of column drive outputs (>=1)
SCAN_DIV, 1000, clk cycles per scan tick (>=2)
DEBOUNCE, 8, consecutive identical ticks required to accept a press or a release (>=1)
CODE_W (localparam), clog2(ROWS*COLS) with minimum 1, key code width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row_i  in  ROWS  keypad rows, active-low (pulled up), asynchronous to clk
col_o  out  COLS  column drive, active-low, exactly one bit low
key_code  out  CODE_W  accepted key, row*COLS+col
key_valid  out  1  key_code holds an unconsumed key
key_ready  in  1  consumer accepts the key when key_valid&&key_ready
key_held  out  1  debounced key is currently pressed
overrun  out  1  sticky: a key was dropped
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, rst_n=0): col_o=~1 (column 0 low), state SCAN, key_code=0, key_valid=0, key_held=0, overrun=0, tick counter=0, debounce counter=0, synchroniser=all ones.
- Tick: counter runs 0..SCAN_DIV-1. tick=1 for one clk when the count is SCAN_DIV-1, then the count wraps to 0. All FSM decisions are made only on tick, using the synchronised rows.
- hit = any synced row low. hit_row = lowest-index low row.
- SCAN: on tick, if hit, latch cand=hit_row*COLS+col, set cnt=1 and go to DEBOUNCE; col_o holds. Otherwise advance col (COLS-1 wraps to 0). If DEBOUNCE==1, go directly to PRESSED instead.
- DEBOUNCE: col_o frozen. On tick, if hit and the code equals cand, increment cnt; reaching cnt==DEBOUNCE moves to PRESSED. Any mismatch or release returns to SCAN and advances col.
- PRESSED: col_o frozen, key_held=1. On entry, emit cand (see output rules). On tick, no hit increments rel_cnt; any hit clears rel_cnt. When rel_cnt reaches DEBOUNCE, go to SCAN, advance col, and set key_held=0.
- Exactly one emit per accepted press; holding a key never repeats.
- Output rules on emit:
  - key_valid=0: load key_code=cand, key_valid=1.
  - key_valid=1 and key_ready=1 in the same cycle: load the new code, key_valid stays 1, no overrun.
  - key_valid=1 and key_ready=0: drop the new code, keep the old key_code, set overrun=1.
- key_valid clears the cycle after key_valid&&key_ready when there is no concurrent emit.
- overrun clears on overrun_clr. If a set and a clear coincide, set wins.
- Latency: once col reaches the pressed key's column, key_valid rises on the DEBOUNCE-th tick, plus 1 clk.
- Multiple rows low in the same column: the lowest row wins. Keys in other columns are not seen while frozen.
- Reset in any state returns to the reset values immediately. A key still held after rst_n rises is re-detected as a new press.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3):
1. Hold rst_n=0 with row_i=4'hF -> col_o=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0; all stay constant.
2. Idle with row_i=4'hF -> col_o steps 1110, 1101, 1011, 0111, 1110, one step every 4 clks; key_valid never rises.
3. Drive row_i[2]=0 while col_o==1101 and hold it -> col_o freezes at 1101, key_valid=1 with key_code=9, key_held=1. Pulse key_ready for 1 clk -> key_valid=0; no further key_valid while held. Release -> after 3 ticks key_held=0 and col_o moves to 1011.
4. Bounce: row_i[2]=0 for only one tick at col 1 -> no key_valid; scanning resumes with col_o=1011.
5. Overrun: key_ready=0. Press and release code 9, then press row 0 at col 3 (code 3) -> key_code stays 9, key_valid=1, overrun=1. Pulse overrun_clr -> overrun=0, key_code still 9.
6. In PRESSED with code 9 held, pulse rst_n=0 mid-tick -> col_o=1110, key_valid=0 and key_held=0 asynchronously. Key still held after rst_n rises -> a new key_valid appears with code 9.
